borrow_skip_subtractor: RTL

- Multi-cycle subtractor: computes diff = a − b − bin, one 4-bit block per clock, LSB block first.
- Counterpart of the team's carry-skip adder; each block uses the same 4-input AND propagate-detect to skip the borrow chain.
- Start/done handshake; operands captured once per operation.
- Sits beside the carry-skip adder in the arithmetic datapath for area-constrained subtract paths.

---
 rtl/borrow_skip_subtractor_if.sv | 27 ++
 rtl/borrow_skip_subtractor.sv | 95 +++++++++
 2 files changed

// File: rtl/borrow_skip_subtractor_if.sv
// Operand/result bundle for borrow_skip_subtractor: start handshake, operands, busy/done, results.
// skip_cnt is present only when BORROW_SKIP_STATS_EN is defined.
interface borrow_skip_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

`ifdef BORROW_SKIP_STATS_EN
  localparam int NBLK = WIDTH / 4;
  localparam int SCW  = $clog2(NBLK + 1);

  logic [SCW-1:0] skip_cnt;

  modport master (output start, a, b, bin, input busy, done, diff, bout, skip_cnt);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, skip_cnt);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/borrow_skip_subtractor.sv
// Sequential borrow-skip subtractor: diff = a - b - bin, one 4-bit block per clock, LSB block first.
// Latency: NBLK busy cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: none; start is sampled only in IDLE. BORROW_SKIP_STATS_EN adds skip_cnt.
module borrow_skip_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  borrow_skip_subtractor_if.slave bus
);
  localparam int NBLK = WIDTH / 4;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_chk
    $error("borrow_skip_subtractor: WIDTH=%0d must be a multiple of 4 and at least 4", WIDTH);
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             brw_q, bout_q;
  logic [IDXW-1:0]  idx;
  logic [3:0]       blk_a, blk_b, blk_diff;
  logic             blk_skip, blk_bout, blk_ripple;

  // Ripple through the current block; the skip path only shortens the borrow chain.
  always_comb begin
    blk_a      = a_q[{idx, 2'b00} +: 4];
    blk_b      = b_q[{idx, 2'b00} +: 4];
    blk_diff   = '0;
    blk_ripple = brw_q;
    for (int j = 0; j < 4; j++) begin
      blk_diff[j] = blk_a[j] ^ blk_b[j] ^ blk_ripple;
      blk_ripple  = (~blk_a[j] & blk_b[j]) | (~(blk_a[j] ^ blk_b[j]) & blk_ripple);
    end
    blk_skip = &(~(blk_a ^ blk_b));
    blk_bout = blk_skip ? brw_q : blk_ripple;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      brw_q  <= 1'b0;
      idx    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      brw_q <= bus.bin;
      idx   <= '0;
    end else if (state == BUSY) begin
      diff_q[{idx, 2'b00} +: 4] <= blk_diff;
      brw_q <= blk_bout;
      idx   <= idx + IDXW'(1);
      if (idx == LAST_IDX) bout_q <= blk_bout;
    end
  end

`ifdef BORROW_SKIP_STATS_EN
  localparam int SCW = $clog2(NBLK + 1);
  logic [SCW-1:0] skip_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            skip_cnt_q <= '0;
    else if ((state == IDLE) && bus.start) skip_cnt_q <= '0;
    else if ((state == BUSY) && blk_skip)  skip_cnt_q <= skip_cnt_q + SCW'(1);
  end

  assign bus.skip_cnt = skip_cnt_q;
`endif

  assign bus.busy = (state == BUSY);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule
